arb8_grant_ctrl: RTL and testbench
==================================

# arb8_grant_ctrl

Sequential 8-requester arbiter that shares one resource (a bus or datapath port) among eight clients using the team's 8:3 priority-encoding rule: the highest active index wins. It adds grant holding, a round-robin mode, and a hold-time limit so that no client is starved. It registers a one-hot grant plus its 3-bit encoded index, so downstream muxes can select directly on `gnt_id`.

## Interface
- `MAX_HOLD`, default 16: maximum consecutive cycles one owner keeps the grant while others wait. Legal range 2..256.
- `clk`  in  1  clock; all logic on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `req`  in  8  request vector; bit i high = client i wants the resource. Level-sensitive.
- `mode`  in  1  0 = fixed priority (7 highest … 0 lowest); 1 = round-robin.
- `gnt`  out  8  registered one-hot grant; all zero when idle.
- `gnt_id`  out  3  binary index of the granted client; 3'd0 when idle.
- `gnt_valid`  out  1  high when `gnt` is non-zero.

## Operation
- State machine with two states:
  - IDLE: no owner.
  - GRANT: `gnt[gnt_id]` is held.
- Internal state:
  - `last` (3 bits): index of the most recent owner.
  - `hold_cnt` (width clog2(MAX_HOLD)): counts edges in GRANT for the current owner.
- Winner selection, evaluated on a candidate vector `c`:
  - Fixed (mode=0): highest set index of `c`. Identical to 8:3 priority encoding.
  - Round-robin (mode=1): circular search starting at (last−1) mod 8 and descending. `last` itself is checked last.
  - `mode` is sampled only at arbitration edges. Changing `mode` mid-grant does not disturb the current owner.
- IDLE:
  - If `req` != 0, the winner over c=`req` is granted. Set `gnt`, `gnt_id`, `gnt_valid`, `last`=winner, `hold_cnt`=0, and go to GRANT.
  - Otherwise remain in IDLE.
- GRANT, evaluated on each edge:
  - Release (`req[gnt_id]`=0): re-arbitrate over c=`req`.
    - If a winner exists, hand over directly with no idle cycle, and reset `hold_cnt`.
    - Otherwise clear all outputs and go to IDLE.
  - Timeout (`req[gnt_id]`=1 and `hold_cnt`==MAX_HOLD−1): re-arbitrate over c=`req` with bit `gnt_id` masked.
    - If a winner exists, hand over to it.
    - If no other requester exists, the current owner keeps the grant.
    - In both cases `hold_cnt` resets to 0.
  - Otherwise: keep the grant and increment `hold_cnt`.
- Requests from non-owners never pre-empt an owner before timeout, in either mode.
- `last` updates only when a new grant is issued, including a re-grant to the same client after timeout.

## Timing
- Reset values: `gnt`=8'h00, `gnt_id`=3'd0, `gnt_valid`=0, state=IDLE, `last`=3'd0, `hold_cnt`=0.
- Because `last`=0 after reset, the first round-robin search starts at index 7. The first decision after reset is therefore the same in both modes.
- `rst` asserted mid-grant: all outputs reach their reset values after that edge, regardless of `req`.
- Grant latency:
  - `req` sampled non-zero at edge k while in IDLE → grant visible after edge k. That is one cycle of latency, with no combinational path from `req` to outputs.
  - `req` rising in the same cycle that `rst` is high is ignored. Arbitration happens at the next edge.
- Release: owner drops `req` before edge k → the new owner, or idle, is visible after edge k. A handover never produces an all-zero `gnt` cycle when other requests are pending.
- Timeout: an owner that continuously requests while others wait holds `gnt` for exactly MAX_HOLD cycles.
- Simultaneous release and timeout on the same edge: release takes precedence. The unmasked `req` is used, so the dropping owner cannot win anyway.
- Invariants every cycle:
  - `gnt` is one-hot or zero.
  - `gnt` == (1 << `gnt_id`) when `gnt_valid`=1.
  - `gnt_valid` == |`gnt`.

## Test plan
- Reset and fixed priority: hold `rst` for 2 cycles with `req`=8'hFF, then release `rst` with mode=0.
  - During reset, `gnt` must be 8'h00.
  - One cycle after release: `gnt`=8'h80, `gnt_id`=7, `gnt_valid`=1.
- Release handover: mode=0, `req`=8'h0A, so client 3 is granted.
  - Drop bit 3 (`req`=8'h02) → next cycle `gnt`=8'h02, `gnt_id`=1, with no zero gap.
  - Then `req`=8'h00 → next cycle `gnt`=8'h00, `gnt_valid`=0.
- Timeout with MAX_HOLD=4, mode=0, `req`=8'h81 held constant:
  - Client 7 holds for exactly 4 cycles, then client 0 for 4 cycles, then client 7 again.
  - Solo case: with `req`=8'h80 alone, client 7 is retained indefinitely.
- Round-robin: mode=1, `req`=8'hFF held, MAX_HOLD=2.
  - Grant order must be 7, 6, 5, 4, 3, 2, 1, 0, 7, … with each client granted for 2 cycles.
  - Set mode=0 mid-sequence: the next arbitration picks 7.
- Reset mid-grant: client 5 is granted, then `rst` is pulsed for 1 cycle while `req`=8'h20 stays high.
  - After the reset edge: `gnt`=8'h00.
  - After the following edge: `gnt`=8'h20.
- Random `req` and `mode` for 10k cycles, checked every cycle:
  - The one-hot, `gnt_id`, and `gnt_valid` invariants hold.
  - No requester waits more than 7×MAX_HOLD+1 cycles in mode=1.

Source files
------------

// File: rtl/arb8_grant_ctrl.sv
// Eight-client arbiter with grant holding, fixed or round-robin selection and a
// hold-time limit; grant, encoded index and valid flag are all registered.
module arb8_grant_ctrl #(
   parameter int unsigned MAX_HOLD = 16
) (
   input  logic       clk_i,
   input  logic       rst_i,
   input  logic [7:0] req_i,
   input  logic       mode_i,
   output logic [7:0] gnt_o,
   output logic [2:0] gnt_id_o,
   output logic       gnt_valid_o
);

   localparam int unsigned HCW = (MAX_HOLD <= 2) ? 1 : $clog2(MAX_HOLD);
   localparam logic [HCW-1:0] HOLD_LAST = HCW'(MAX_HOLD - 1);

   typedef enum logic [0:0] {
      IDLE  = 1'b0,
      GRANT = 1'b1
   } state_t;

   state_t           state_q;
   logic [2:0]       last_q;
   logic [HCW-1:0]   hold_cnt_q;
   logic [7:0]       gnt_q;
   logic [2:0]       gnt_id_q;
   logic             gnt_valid_q;

   logic             owner_req_s;
   logic             timeout_s;
   logic [7:0]       cand_s;
   logic             win_any_s;
   logic [2:0]       win_id_s;
   logic             issue_s;
   logic             regrant_s;

   // Highest set index wins; same result as a plain 8:3 priority encoder.
   function automatic logic [2:0] fixed_pick(input logic [7:0] c);
      logic [2:0] idx;
      idx = 3'd0;
      for (int i = 0; i < 8; i++) begin
         idx = c[i] ? 3'(i) : idx;
      end
      return idx;
   endfunction

   // Descending circular search from last-1; last itself has the lowest priority.
   function automatic logic [2:0] rr_pick(input logic [7:0] c, input logic [2:0] last);
      logic [2:0] idx;
      logic [2:0] off;
      idx = 3'd0;
      for (int i = 8; i >= 1; i--) begin
         off = last - 3'(i);
         idx = c[off] ? off : idx;
      end
      return idx;
   endfunction

   function automatic logic [7:0] onehot8(input logic [2:0] idx);
      return 8'h01 << idx;
   endfunction

   // Candidate selection and the arbitration decision for this edge.
   always_comb begin
      owner_req_s = req_i[gnt_id_q];
      timeout_s   = (state_q == GRANT) && owner_req_s && (hold_cnt_q == HOLD_LAST);
      if (timeout_s) begin
         cand_s = req_i & ~onehot8(gnt_id_q);
      end else begin
         cand_s = req_i;
      end
      win_any_s = |cand_s;
      if (mode_i) begin
         win_id_s = rr_pick(cand_s, last_q);
      end else begin
         win_id_s = fixed_pick(cand_s);
      end
      if (state_q == IDLE) begin
         issue_s = win_any_s;
      end else begin
         issue_s = win_any_s && (!owner_req_s || timeout_s);
      end
      regrant_s = timeout_s && !win_any_s;
   end

   // Grant state machine with registered outputs.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q     <= IDLE;
         last_q      <= 3'd0;
         hold_cnt_q  <= '0;
         gnt_q       <= 8'h00;
         gnt_id_q    <= 3'd0;
         gnt_valid_q <= 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               if (issue_s) begin
                  state_q     <= GRANT;
                  last_q      <= win_id_s;
                  hold_cnt_q  <= '0;
                  gnt_q       <= onehot8(win_id_s);
                  gnt_id_q    <= win_id_s;
                  gnt_valid_q <= 1'b1;
               end else begin
                  state_q     <= IDLE;
               end
            end
            GRANT: begin
               if (issue_s) begin
                  last_q      <= win_id_s;
                  hold_cnt_q  <= '0;
                  gnt_q       <= onehot8(win_id_s);
                  gnt_id_q    <= win_id_s;
                  gnt_valid_q <= 1'b1;
               end else if (regrant_s) begin
                  // Sole requester at timeout keeps the resource; counts as a new grant.
                  last_q      <= gnt_id_q;
                  hold_cnt_q  <= '0;
               end else if (!owner_req_s) begin
                  state_q     <= IDLE;
                  hold_cnt_q  <= '0;
                  gnt_q       <= 8'h00;
                  gnt_id_q    <= 3'd0;
                  gnt_valid_q <= 1'b0;
               end else begin
                  hold_cnt_q  <= hold_cnt_q + HCW'(1);
               end
            end
            default: begin
               state_q     <= IDLE;
               hold_cnt_q  <= '0;
               gnt_q       <= 8'h00;
               gnt_id_q    <= 3'd0;
               gnt_valid_q <= 1'b0;
            end
         endcase
      end
   end

   assign gnt_o       = gnt_q;
   assign gnt_id_o    = gnt_id_q;
   assign gnt_valid_o = gnt_valid_q;

endmodule

// File: tb/tb_arb8_grant_ctrl.sv
// Bench for arb8_grant_ctrl: directed vector table, multi-cycle corner sequences
// and a random phase checking output invariants and round-robin wait bounds.
module tb_arb8_grant_ctrl;

   logic       clk = 1'b0;
   logic       rst;
   logic       mode;
   logic [7:0] req;
   logic [7:0] gnt4, gnt2;
   logic [2:0] id4, id2;
   logic       v4, v2;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   arb8_grant_ctrl #(.MAX_HOLD(4)) u4 (
      .clk_i(clk), .rst_i(rst), .req_i(req), .mode_i(mode),
      .gnt_o(gnt4), .gnt_id_o(id4), .gnt_valid_o(v4)
   );

   arb8_grant_ctrl #(.MAX_HOLD(2)) u2 (
      .clk_i(clk), .rst_i(rst), .req_i(req), .mode_i(mode),
      .gnt_o(gnt2), .gnt_id_o(id2), .gnt_valid_o(v2)
   );

   typedef struct {
      logic       rst;
      logic [7:0] req;
      logic       mode;
      logic [7:0] gnt;
      logic [2:0] id;
      logic       v;
   } vec_t;

   vec_t tbl [14];
   int   w4 [8];
   int   w2 [8];

   task automatic check(input string name, input bit ok, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (!ok) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic check_out(input string tag, input logic [7:0] g, input logic [2:0] i, input logic v,
                            input logic [7:0] eg, input logic [2:0] ei, input logic ev);
      check({tag, ".gnt"},   g == eg, 32'(g), 32'(eg));
      check({tag, ".id"},    i == ei, 32'(i), 32'(ei));
      check({tag, ".valid"}, v == ev, 32'(v), 32'(ev));
   endtask

   task automatic check_inv(input string tag, input logic [7:0] g, input logic [2:0] i, input logic v);
      check({tag, ".onehot"}, $onehot0(g), 32'(g), 32'h0);
      check({tag, ".valid"},  v == (|g), 32'(v), 32'(|g));
      check({tag, ".gnt_id"}, v ? (g == (8'h01 << i)) : (i == 3'd0), 32'(i), 32'(g));
   endtask

   initial begin
      logic [7:0] eg;
      logic [2:0] ei;
      rst  = 1'b1;
      req  = 8'h00;
      mode = 1'b0;

      // rst, req, mode, expected gnt, id, valid (u4)
      tbl[0]  = '{1'b1, 8'hFF, 1'b0, 8'h00, 3'd0, 1'b0};
      tbl[1]  = '{1'b1, 8'hFF, 1'b0, 8'h00, 3'd0, 1'b0};
      tbl[2]  = '{1'b0, 8'hFF, 1'b0, 8'h80, 3'd7, 1'b1};
      tbl[3]  = '{1'b0, 8'h00, 1'b0, 8'h00, 3'd0, 1'b0};
      tbl[4]  = '{1'b0, 8'h0A, 1'b0, 8'h08, 3'd3, 1'b1};
      tbl[5]  = '{1'b0, 8'h02, 1'b0, 8'h02, 3'd1, 1'b1};
      tbl[6]  = '{1'b0, 8'h00, 1'b0, 8'h00, 3'd0, 1'b0};
      tbl[7]  = '{1'b0, 8'h01, 1'b0, 8'h01, 3'd0, 1'b1};
      tbl[8]  = '{1'b0, 8'h81, 1'b0, 8'h01, 3'd0, 1'b1};
      tbl[9]  = '{1'b0, 8'h00, 1'b0, 8'h00, 3'd0, 1'b0};
      tbl[10] = '{1'b0, 8'h24, 1'b1, 8'h20, 3'd5, 1'b1};
      tbl[11] = '{1'b0, 8'h00, 1'b1, 8'h00, 3'd0, 1'b0};
      tbl[12] = '{1'b0, 8'h24, 1'b1, 8'h04, 3'd2, 1'b1};
      tbl[13] = '{1'b0, 8'h00, 1'b0, 8'h00, 3'd0, 1'b0};

      for (int k = 0; k < 14; k++) begin
         rst  = tbl[k].rst;
         req  = tbl[k].req;
         mode = tbl[k].mode;
         step();
         check_out($sformatf("vec%0d", k), gnt4, id4, v4, tbl[k].gnt, tbl[k].id, tbl[k].v);
      end

      // Timeout alternation with MAX_HOLD=4, then sole requester retention.
      rst = 1'b1; req = 8'h00; mode = 1'b0;
      step();
      rst = 1'b0; req = 8'h81;
      for (int n = 0; n < 12; n++) begin
         step();
         eg = (((n / 4) % 2) == 0) ? 8'h80 : 8'h01;
         check($sformatf("timeout.c%0d", n), gnt4 == eg, 32'(gnt4), 32'(eg));
      end
      req = 8'h80;
      for (int n = 0; n < 10; n++) begin
         step();
         check($sformatf("solo.c%0d", n), gnt4 == 8'h80, 32'(gnt4), 32'h80);
      end

      // Round-robin rotation with MAX_HOLD=2, then a mid-grant switch to fixed.
      rst = 1'b1; req = 8'h00; mode = 1'b0;
      step();
      rst = 1'b0; req = 8'hFF; mode = 1'b1;
      for (int n = 0; n < 25; n++) begin
         step();
         if (n < 20) begin
            ei = 3'(7 - ((n / 2) % 8));
         end else begin
            ei = ((((n - 20) / 2) % 2) == 0) ? 3'd7 : 3'd6;
         end
         check($sformatf("rr.id.c%0d", n), id2 == ei, 32'(id2), 32'(ei));
         check($sformatf("rr.gnt.c%0d", n), gnt2 == (8'h01 << ei), 32'(gnt2), 32'(8'h01 << ei));
         if (n == 18) mode = 1'b0;
      end

      // Reset pulse while client 5 owns the grant.
      rst = 1'b1; req = 8'h00; mode = 1'b0;
      step();
      rst = 1'b0; req = 8'h20;
      step();
      check_out("midrst.pre", gnt4, id4, v4, 8'h20, 3'd5, 1'b1);
      step();
      rst = 1'b1;
      step();
      check_out("midrst.rst", gnt4, id4, v4, 8'h00, 3'd0, 1'b0);
      rst = 1'b0;
      step();
      check_out("midrst.post", gnt4, id4, v4, 8'h20, 3'd5, 1'b1);

      // Round-robin random traffic with wait bounds: requests stay up until served.
      rst = 1'b1; req = 8'h00; mode = 1'b1;
      step();
      rst = 1'b0;
      for (int i = 0; i < 8; i++) begin
         w4[i] = 0;
         w2[i] = 0;
      end
      for (int n = 0; n < 5000; n++) begin
         for (int i = 0; i < 8; i++) begin
            if (gnt4[i]) begin
               if ($urandom_range(3) == 0) req[i] = 1'b0;
            end else if (!req[i] && ($urandom_range(2) == 0)) begin
               req[i] = 1'b1;
            end
         end
         step();
         check_inv("rr4", gnt4, id4, v4);
         check_inv("rr2", gnt2, id2, v2);
         for (int i = 0; i < 8; i++) begin
            w4[i] = (req[i] && !gnt4[i]) ? w4[i] + 1 : 0;
            w2[i] = (req[i] && !gnt2[i]) ? w2[i] + 1 : 0;
            check($sformatf("starve4.c%0d", i), w4[i] <= 29, 32'(w4[i]), 32'd29);
            check($sformatf("starve2.c%0d", i), w2[i] <= 15, 32'(w2[i]), 32'd15);
         end
      end

      // Fully random req and mode: invariants only.
      for (int n = 0; n < 5000; n++) begin
         req  = 8'($urandom);
         mode = 1'($urandom_range(1));
         step();
         check_inv("rnd4", gnt4, id4, v4);
         check_inv("rnd2", gnt2, id2, v2);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
